bf_bus_controller: RTL and testbench
====================================

Name: bf_bus_controller

Overview:
- Sequences the shared 4-bit address / 8-bit data bus of the BrainFuzz interpreter's program ROM and data RAM.
- Arbitrates two requesters:
  - Instruction-fetch port, read-only, always targets ROM.
  - Data port, read/write, always targets RAM.
- Generates the active-low chip-enable, write-enable and output-enable strobes with setup/access/hold phasing.
- Sits between the interpreter core and the ROM_chip/RAM_chip pair. The top level merges bus_dout/bus_doe into the tristate data bus.

Parameters:
- ADDR_W, 4, bus address width.
- DATA_W, 8, bus data width.
- WAIT_CYCLES, 1, number of cycles the OEb/WEb strobe stays low (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rstb  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held high with if_addr stable until if_ack.
- if_addr  in  ADDR_W  fetch (ROM) address.
- if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid.
- if_rdata  out  DATA_W  last fetched byte; held until the next fetch completes.
- dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata stable until dm_ack.
- dm_we  in  1  1 = write RAM, 0 = read RAM.
- dm_addr  in  ADDR_W  RAM address.
- dm_wdata  in  DATA_W  write data.
- dm_ack  out  1  one-cycle pulse: data access complete.
- dm_rdata  out  DATA_W  last RAM read byte; held until the next data read completes.
- bus_addr  out  ADDR_W  shared address bus.
- bus_din  in  DATA_W  shared data bus, input side.
- bus_dout  out  DATA_W  shared data bus, driven value.
- bus_doe  out  1  1 = controller drives the data bus.
- rom_ceb  out  1  ROM chip enable, active low.
- ram_ceb  out  1  RAM chip enable, active low.
- ram_web  out  1  RAM write enable, active low.
- ram_oeb  out  1  RAM output enable, active low (ROM reads are gated by rom_ceb alone).

Behaviour:
- Reset (rstb low, async), all outputs registered:
  - state=IDLE; rom_ceb, ram_ceb, ram_web, ram_oeb = 1; bus_doe=0; bus_addr=0; bus_dout=0; if_ack, dm_ack = 0; if_rdata, dm_rdata = 0; rr_last=FETCH (data wins first tie).
  - Reset mid-access abandons the access immediately with strobes deasserted; no ack is issued.
- FSM states:
  - IDLE: sample requests.
    - Only one pending: grant it.
    - Both pending: grant the port not served last (round robin); update rr_last on grant.
    - Latch port, addr, we and wdata into internal registers → SETUP.
  - SETUP (1 cycle):
    - bus_addr valid; selected CEb low.
    - Write: bus_dout=wdata, bus_doe=1.
    - OEb/WEb still high.
    - → ACCESS with wait counter = WAIT_CYCLES-1.
  - ACCESS (WAIT_CYCLES cycles):
    - Read: ram_oeb low for RAM. For ROM, rom_ceb low is sufficient.
    - Write: ram_web low.
    - Counter decrements; at 0 → HOLD.
    - Read data is captured from bus_din at the clock edge leaving the last ACCESS cycle.
  - HOLD (1 cycle):
    - OEb/WEb high; CEb still low; bus_addr and bus_dout/bus_doe held (write hold time).
    - The granted port's ack is high this cycle; rdata is already updated.
    - → IDLE, with CEb high and bus_doe=0 from the next cycle.
- Latency: request seen in IDLE at cycle 0 → ack in cycle 2+WAIT_CYCLES. Min request-to-request throughput is 3+WAIT_CYCLES cycles.
- A requester drops req the cycle after its ack. A req still high in IDLE after ack is treated as a new request.
- Both CEbs are never low simultaneously. bus_doe is never 1 while ram_oeb=0 or rom_ceb=0.
- Requests arriving during a busy state wait; no request is lost or reordered within a port.

Optional Feature:
- BUS_TURNAROUND_EN:
  - Defined: when the granted access is a write and the previous completed access was a read (either chip), insert one TURN state between IDLE and SETUP. All strobes are high and bus_doe=0 during TURN. Write latency becomes 3+WAIT_CYCLES in that case.
  - Undefined: no TURN state; IDLE goes directly to SETUP.

Decomposition:
- Package bf_bus_pkg:
  - state enum (IDLE, TURN, SETUP, ACCESS, HOLD);
  - port-select enum (FETCH, DATA);
  - default ADDR_W/DATA_W constants.
- One sub-module: bf_rr_arbiter, a 2-way round-robin grant with rr_last register.
- FSM, strobe generation and data capture stay in bf_bus_controller.

Test Plan:
- Reset: rstb low mid-ACCESS of a RAM write → next sample shows ram_web=1, ram_ceb=1, bus_doe=0, no dm_ack, state IDLE.
- Fetch: if_req addr=4'h3, ROM model returns 8'hA5, WAIT_CYCLES=1 → rom_ceb low cycles 1–3, if_ack pulse at cycle 3, if_rdata=8'hA5.
- RAM write then read: dm write addr=4'h7 data=8'h3C, then read addr=4'h7 → dm_rdata=8'h3C; ram_web low exactly WAIT_CYCLES cycles; bus_doe high from SETUP through HOLD.
- Contention: if_req and dm_req asserted together repeatedly for 4 accesses → grants alternate DATA, FETCH, DATA, FETCH; ram_ceb and rom_ceb never low together.
- WAIT_CYCLES=3: RAM read → ram_oeb low 3 cycles, dm_ack at cycle 5 after request.
- BUS_TURNAROUND_EN defined: read addr=4'h1, then immediate write addr=4'h2 → one cycle with all strobes high and bus_doe=0 before the write's SETUP; write ack latency is 4 cycles.

Source files
------------

// File: rtl/bf_bus_pkg.sv
// Shared types and constants for the BrainFuzz ROM/RAM bus controller.
package bf_bus_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W      = 4;

  typedef enum logic [2:0] {IDLE, TURN, SETUP, ACCESS, HOLD} state_t;
  typedef enum logic {FETCH = 1'b0, DATA = 1'b1} port_t;

  // Wait counter load value; the strobe stays low for w cycles.
  function automatic logic [CNT_W-1:0] wait_load(input int w);
    return CNT_W'(w - 1);
  endfunction

endpackage

// File: rtl/bf_bus_controller_if.sv
// Request/ack ports of the core plus the shared ROM/RAM bus pins.
interface bf_bus_controller_if #(
  parameter int ADDR_W = bf_bus_pkg::ADDR_W_DEF,
  parameter int DATA_W = bf_bus_pkg::DATA_W_DEF
) ();
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_din;
  logic [DATA_W-1:0] bus_dout;
  logic              bus_doe;
  logic              rom_ceb;
  logic              ram_ceb;
  logic              ram_web;
  logic              ram_oeb;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, bus_din,
    output if_ack, if_rdata, dm_ack, dm_rdata, bus_addr, bus_dout, bus_doe,
           rom_ceb, ram_ceb, ram_web, ram_oeb
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, bus_din,
    input  if_ack, if_rdata, dm_ack, dm_rdata, bus_addr, bus_dout, bus_doe,
           rom_ceb, ram_ceb, ram_web, ram_oeb
  );
endinterface

// File: rtl/bf_rr_arbiter.sv
// Two-way round-robin grant between the fetch and data ports.
module bf_rr_arbiter
  import bf_bus_pkg::*;
(
  input  logic  clk,
  input  logic  rstb,
  input  logic  req_fetch,
  input  logic  req_data,
  input  logic  take,
  output logic  gnt_vld,
  output port_t gnt_port
);
  port_t rr_last;

  always_comb begin
    gnt_vld  = req_fetch | req_data;
    gnt_port = FETCH;
    if (req_fetch && req_data) gnt_port = (rr_last == FETCH) ? DATA : FETCH;
    else if (req_data)         gnt_port = DATA;
  end

  // Reset to FETCH so the data port wins the first tie.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)                rr_last <= FETCH;
    else if (take && gnt_vld) rr_last <= gnt_port;
  end
endmodule

// File: rtl/bf_bus_controller.sv
// Shared ROM/RAM bus sequencer: arbitration, CE/OE/WE phasing, read capture.
// Optional BUS_TURNAROUND_EN inserts a TURN cycle before a write that follows a read.
module bf_bus_controller
  import bf_bus_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 1
) (
  input logic                clk,
  input logic                rstb,
  bf_bus_controller_if.slave bif
);
  state_t            state;
  port_t             port_q, gnt_port, n_port;
  logic              we_q, n_we, gnt_vld, need_turn, go_setup;
  logic [ADDR_W-1:0] addr_q, n_addr;
  logic [DATA_W-1:0] wdata_q, n_wdata;
  logic [CNT_W-1:0]  cnt;
`ifdef BUS_TURNAROUND_EN
  logic              last_rd;
`endif

  bf_rr_arbiter u_arb (
    .clk      (clk),
    .rstb     (rstb),
    .req_fetch(bif.if_req),
    .req_data (bif.dm_req),
    .take     (state == IDLE),
    .gnt_vld  (gnt_vld),
    .gnt_port (gnt_port)
  );

  // Access parameters come straight from the winner in IDLE, from the latches after TURN.
  always_comb begin
    n_port  = port_q;
    n_we    = we_q;
    n_addr  = addr_q;
    n_wdata = wdata_q;
    if (state == IDLE) begin
      n_port  = gnt_port;
      n_we    = (gnt_port == DATA) && bif.dm_we;
      n_addr  = (gnt_port == DATA) ? bif.dm_addr : bif.if_addr;
      n_wdata = bif.dm_wdata;
    end
  end

`ifdef BUS_TURNAROUND_EN
  assign need_turn = n_we && last_rd;
`else
  assign need_turn = 1'b0;
`endif
  assign go_setup = (state == IDLE && gnt_vld && !need_turn) || (state == TURN);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state        <= IDLE;
      port_q       <= FETCH;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt          <= '0;
      bif.rom_ceb  <= 1'b1;
      bif.ram_ceb  <= 1'b1;
      bif.ram_web  <= 1'b1;
      bif.ram_oeb  <= 1'b1;
      bif.bus_doe  <= 1'b0;
      bif.bus_addr <= '0;
      bif.bus_dout <= '0;
      bif.if_ack   <= 1'b0;
      bif.dm_ack   <= 1'b0;
      bif.if_rdata <= '0;
      bif.dm_rdata <= '0;
`ifdef BUS_TURNAROUND_EN
      last_rd      <= 1'b0;
`endif
    end else begin
      bif.if_ack <= 1'b0;
      bif.dm_ack <= 1'b0;

      if (go_setup) begin
        bif.bus_addr <= n_addr;
        bif.rom_ceb  <= (n_port != FETCH);
        bif.ram_ceb  <= (n_port != DATA);
        bif.bus_doe  <= n_we;
        if (n_we) bif.bus_dout <= n_wdata;
      end

      case (state)
        IDLE: if (gnt_vld) begin
          port_q  <= n_port;
          we_q    <= n_we;
          addr_q  <= n_addr;
          wdata_q <= n_wdata;
          state   <= need_turn ? TURN : SETUP;
        end
`ifdef BUS_TURNAROUND_EN
        TURN: state <= SETUP;
`endif
        SETUP: begin
          state <= ACCESS;
          cnt   <= wait_load(WAIT_CYCLES);
          if (we_q)                 bif.ram_web <= 1'b0;
          else if (port_q == DATA)  bif.ram_oeb <= 1'b0;
        end
        ACCESS: begin
          if (cnt == '0) begin
            state       <= HOLD;
            bif.ram_web <= 1'b1;
            bif.ram_oeb <= 1'b1;
            bif.if_ack  <= (port_q == FETCH);
            bif.dm_ack  <= (port_q == DATA);
            if (!we_q) begin
              if (port_q == FETCH) bif.if_rdata <= bif.bus_din;
              else                 bif.dm_rdata <= bif.bus_din;
            end
`ifdef BUS_TURNAROUND_EN
            last_rd <= !we_q;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          state       <= IDLE;
          bif.rom_ceb <= 1'b1;
          bif.ram_ceb <= 1'b1;
          bif.bus_doe <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bf_bus_controller.sv
// Scoreboard bench: WAIT_CYCLES=1 and WAIT_CYCLES=3 controllers on ROM/RAM models.
module tb_bf_bus_controller;
  import bf_bus_pkg::*;
`ifdef BUS_TURNAROUND_EN
  localparam bit TURN_EN = 1'b1;
`else
  localparam bit TURN_EN = 1'b0;
`endif

  typedef struct {
    port_t      port;
    logic       chk;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q [2][$];
  bit   last_rd [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bf_bus_controller_if #(.ADDR_W(4), .DATA_W(8)) b1 ();
  bf_bus_controller_if #(.ADDR_W(4), .DATA_W(8)) b3 ();

  bf_bus_controller #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(1)) u_dut1 (.clk(clk), .rstb(rstb), .bif(b1));
  bf_bus_controller #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(3)) u_dut3 (.clk(clk), .rstb(rstb), .bif(b3));

  // ROM/RAM chip models
  logic [7:0] rom [16];
  logic [7:0] ram1 [16];
  logic [7:0] ram3 [16];

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = {4'(i), ~4'(i)};
    rom[3] = 8'hA5;
  end

  always_comb begin
    b1.bus_din = 8'h00;
    if (!b1.rom_ceb)                      b1.bus_din = rom[b1.bus_addr];
    else if (!b1.ram_ceb && !b1.ram_oeb)  b1.bus_din = ram1[b1.bus_addr];
  end
  always_comb begin
    b3.bus_din = 8'h00;
    if (!b3.rom_ceb)                      b3.bus_din = rom[b3.bus_addr];
    else if (!b3.ram_ceb && !b3.ram_oeb)  b3.bus_din = ram3[b3.bus_addr];
  end
  always @(posedge clk) begin
    if (!b1.ram_ceb && !b1.ram_web && b1.bus_doe) ram1[b1.bus_addr] <= b1.bus_dout;
    if (!b3.ram_ceb && !b3.ram_web && b3.bus_doe) ram3[b3.bus_addr] <= b3.bus_dout;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // {if_ack, dm_ack, rom_ceb, ram_ceb, ram_web, ram_oeb, bus_doe}
  function automatic logic [6:0] snap(input int k);
    if (k == 0) return {b1.if_ack, b1.dm_ack, b1.rom_ceb, b1.ram_ceb, b1.ram_web, b1.ram_oeb, b1.bus_doe};
    return {b3.if_ack, b3.dm_ack, b3.rom_ceb, b3.ram_ceb, b3.ram_web, b3.ram_oeb, b3.bus_doe};
  endfunction

  task automatic drive(input int k, input port_t p, input logic r, input logic we,
                       input logic [3:0] a, input logic [7:0] wd);
    if (k == 0) begin
      if (p == FETCH) begin b1.if_req = r; b1.if_addr = a; end
      else begin b1.dm_req = r; b1.dm_we = we; b1.dm_addr = a; b1.dm_wdata = wd; end
    end else begin
      if (p == FETCH) begin b3.if_req = r; b3.if_addr = a; end
      else begin b3.dm_req = r; b3.dm_we = we; b3.dm_addr = a; b3.dm_wdata = wd; end
    end
  endtask

  task automatic expect_ack(input int k, input port_t p, input logic chk, input logic [7:0] d, input int c);
    exp_t e;
    e.port = p; e.chk = chk; e.data = d; e.cyc = c;
    q[k].push_back(e);
  endtask

  // Monitor: pops one expectation per ack pulse and checks port, timing and data.
  task automatic mon(input int k);
    logic [6:0] s;
    logic [7:0] rd;
    exp_t       e;
    s = snap(k);
    if (!(s[6] || s[5])) return;
    if (q[k].size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL unexpected_ack dut%0d: got if_ack=%0b dm_ack=%0b, expected none", k, s[6], s[5]);
      return;
    end
    e = q[k].pop_front();
    check($sformatf("ack_port dut%0d", k), {s[6], s[5]}, (e.port == FETCH) ? 2'b10 : 2'b01);
    check($sformatf("ack_cycle dut%0d", k), cyc, e.cyc);
    if (k == 0) rd = (e.port == FETCH) ? b1.if_rdata : b1.dm_rdata;
    else        rd = (e.port == FETCH) ? b3.if_rdata : b3.dm_rdata;
    if (e.chk) check($sformatf("rdata dut%0d", k), rd, e.data);
  endtask

  task automatic strobe_rules(input int k);
    logic [6:0] s;
    s = snap(k);
    check($sformatf("strobe_rules dut%0d", k),
          (!s[4] && !s[3]) || (s[0] && (!s[1] || !s[4])), 1'b0);
  endtask

  always @(negedge clk) begin
    if (rstb) begin
      strobe_rules(0); strobe_rules(1);
      mon(0); mon(1);
    end
  end

  // One complete access; checks strobe phasing while the monitor checks the ack.
  task automatic access(input int k, input port_t p, input logic we, input logic [3:0] a,
                        input logic [7:0] wd, input logic [7:0] rd);
    int         w, pre, ce_n, stb_n, doe_n;
    bit         turn, seen, got;
    logic [6:0] s;
    w = (k == 0) ? 1 : 3;
    turn = TURN_EN && we && last_rd[k];
    pre = 0; ce_n = 0; stb_n = 0; doe_n = 0; seen = 0; got = 0;
    @(posedge clk); #1;
    expect_ack(k, p, !we, rd, cyc + 2 + w + int'(turn));
    drive(k, p, 1'b1, we, a, wd);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      s = snap(k);
      if (s[4] && s[3] && !seen) pre++;
      else seen = 1'b1;
      if ((p == FETCH) ? !s[4] : !s[3]) ce_n++;
      if (we ? !s[2] : !s[1]) stb_n++;
      if (s[0]) doe_n++;
      got = (p == FETCH) ? s[6] : s[5];
    end
    drive(k, p, 1'b0, we, a, wd);
    check("ack_seen", got, 1'b1);
    check("idle_cycles_before_setup", pre, turn ? 2 : 1);
    check("ceb_low_cycles", ce_n, w + 2);
    check("oeb_web_low_cycles", stb_n, (p == FETCH) ? 0 : w);
    check("doe_cycles", doe_n, we ? w + 2 : 0);
    last_rd[k] = !we;
  endtask

  initial begin
    int   t0, nd, nf;
    logic got, ack_in_rst;
    drive(0, FETCH, 1'b0, 1'b0, 4'h0, 8'h00);
    drive(0, DATA,  1'b0, 1'b0, 4'h0, 8'h00);
    drive(1, FETCH, 1'b0, 1'b0, 4'h0, 8'h00);
    drive(1, DATA,  1'b0, 1'b0, 4'h0, 8'h00);
    repeat (3) @(negedge clk);
    check("reset_state dut1", {snap(0), b1.bus_addr, b1.bus_dout, b1.if_rdata, b1.dm_rdata}, {7'b0011110, 28'h0});
    check("reset_state dut3", {snap(1), b3.bus_addr, b3.bus_dout, b3.if_rdata, b3.dm_rdata}, {7'b0011110, 28'h0});
    rstb = 1'b1;

    // WAIT_CYCLES=1: fetch, writes, read-back, then a fetch so FETCH was served last
    access(0, FETCH, 1'b0, 4'h3, 8'h00, 8'hA5);
    access(0, DATA,  1'b1, 4'h1, 8'h5E, 8'h00);
    access(0, DATA,  1'b1, 4'h7, 8'h3C, 8'h00);
    access(0, DATA,  1'b0, 4'h7, 8'h00, 8'h3C);
    access(0, FETCH, 1'b0, 4'h9, 8'h00, 8'h96);

    // Contention: both held high, order must be DATA, FETCH, DATA, FETCH
    @(posedge clk); #1;
    t0 = cyc;
    expect_ack(0, DATA,  1'b1, 8'h3C, t0 + 3);
    expect_ack(0, FETCH, 1'b1, 8'hA5, t0 + 7);
    expect_ack(0, DATA,  1'b1, 8'h3C, t0 + 11);
    expect_ack(0, FETCH, 1'b1, 8'hA5, t0 + 15);
    drive(0, FETCH, 1'b1, 1'b0, 4'h3, 8'h00);
    drive(0, DATA,  1'b1, 1'b0, 4'h7, 8'h00);
    nd = 0; nf = 0;
    for (int i = 0; i < 60 && (nd < 2 || nf < 2); i++) begin
      @(negedge clk);
      if (b1.dm_ack) begin nd++; if (nd == 2) b1.dm_req = 1'b0; end
      if (b1.if_ack) begin nf++; if (nf == 2) b1.if_req = 1'b0; end
    end
    b1.dm_req = 1'b0; b1.if_req = 1'b0;
    check("contention_ack_counts", {nd[7:0], nf[7:0]}, 16'h0202);
    last_rd[0] = 1'b1;

    // Read followed by a write: turnaround cycle when enabled
    access(0, DATA, 1'b0, 4'h1, 8'h00, 8'h5E);
    access(0, DATA, 1'b1, 4'h2, 8'h81, 8'h00);
    access(0, DATA, 1'b0, 4'h2, 8'h00, 8'h81);

    // WAIT_CYCLES=3
    access(1, DATA,  1'b1, 4'h4, 8'hC3, 8'h00);
    access(1, DATA,  1'b0, 4'h4, 8'h00, 8'hC3);
    access(1, FETCH, 1'b0, 4'h3, 8'h00, 8'hA5);

    // Reset in the middle of a RAM write
    @(posedge clk); #1;
    drive(0, DATA, 1'b1, 1'b1, 4'hE, 8'h77);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = !b1.ram_web;
    end
    check("reached_write_access", got, 1'b1);
    rstb = 1'b0;
    #1;
    check("reset_mid_write {web,ceb,doe,ack,idle}",
          {b1.ram_web, b1.ram_ceb, b1.bus_doe, b1.dm_ack, u_dut1.state == IDLE}, 5'b11001);
    drive(0, DATA, 1'b0, 1'b0, 4'h0, 8'h00);
    ack_in_rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      ack_in_rst = ack_in_rst | b1.dm_ack;
    end
    check("no_ack_during_reset", ack_in_rst, 1'b0);
    rstb = 1'b1;
    repeat (4) @(negedge clk);
    check("scoreboard_drained", q[0].size() + q[1].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
